cordic_iter: RTL and testbench

//  Multi-cycle iterative CORDIC engine, one micro-rotation per clock on a shared datapath.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic_stage.sv | 26 ++
 rtl/cordic_iter.sv | 144 ++++++++++++++
 tb/tb_cordic_iter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared state encoding, mode encoding and constant tables for the iterative CORDIC engine.
package cordic_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t COMP = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // round(atan(2^-i) * 2^frac), valid for frac 0..32. Entries are held at 2^32 scale;
    // from i = 11 on, atan(2^-i) sits within half an LSB of 2^-i even at 2^32 scale.
    function automatic logic [63:0] alpha(input int i, input int frac);
        logic [63:0] t;
        if (i >= 11) begin
            return (i <= frac) ? (64'd1 << (frac - i)) : 64'd0;
        end
        case (i)
            0:       t = 64'd3373259426;
            1:       t = 64'd1991351318;
            2:       t = 64'd1052175346;
            3:       t = 64'd534100635;
            4:       t = 64'd268086748;
            5:       t = 64'd134174063;
            6:       t = 64'd67103403;
            7:       t = 64'd33553749;
            8:       t = 64'd16777131;
            9:       t = 64'd8388597;
            default: t = 64'd4194303;
        endcase
        return ((t << frac) + 64'h8000_0000) >> 32;
    endfunction

    // round(0.6072529350 * 2^frac), valid for frac 0..32.
    function automatic logic [63:0] k_gain(input int frac);
        return ((64'd2608131496 << frac) + 64'h8000_0000) >> 32;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; d selects the rotation direction.
module cordic_stage #(
    parameter int WL = 21,
    parameter int SW = 5
) (
    input  logic signed [WL-1:0] x_i,
    input  logic signed [WL-1:0] y_i,
    input  logic signed [WL-1:0] z_i,
    input  logic signed [WL-1:0] alpha_i,
    input  logic        [SW-1:0] shift_i,
    input  logic                 d_i,
    output logic signed [WL-1:0] x_o,
    output logic signed [WL-1:0] y_o,
    output logic signed [WL-1:0] z_o
);

    logic signed [WL-1:0] sx, sy;

    assign sx = x_i >>> shift_i;
    assign sy = y_i >>> shift_i;

    assign x_o = d_i ? (x_i + sy) : (x_i - sy);
    assign y_o = d_i ? (y_i - sx) : (y_i + sx);
    assign z_o = d_i ? (z_i + alpha_i) : (z_i - alpha_i);

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock through a single shared stage.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales x/y by K ~= 1/An.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH = 21,
    parameter int FRAC_BITS   = 16,
    parameter int ITERATIONS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          mode_i,
    input  logic signed [WORD_LENGTH-1:0] x_i,
    input  logic signed [WORD_LENGTH-1:0] y_i,
    input  logic signed [WORD_LENGTH-1:0] z_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic signed [WORD_LENGTH-1:0] x_o,
    output logic signed [WORD_LENGTH-1:0] y_o,
    output logic signed [WORD_LENGTH-1:0] z_o,
    output logic                          busy_o
);

    localparam int WL = WORD_LENGTH;
    localparam int CW = $clog2(ITERATIONS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    state_t               state_q, state_d;
    logic signed [WL-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
    logic signed [WL-1:0] x_nx, y_nx, z_nx;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 dir;

    logic signed [WL-1:0] alpha_rom [2**CW];
    for (genvar g = 0; g < 2**CW; g++) begin : g_rom
        if (g < ITERATIONS) begin : g_used
            assign alpha_rom[g] = WL'(alpha(g, FRAC_BITS));
        end else begin : g_pad
            assign alpha_rom[g] = '0;
        end
    end

    // Vectoring treats y == 0 as non-negative; rotation treats z == 0 the same way.
    assign dir = (mode_q == MODE_VEC) ? ~y_q[WL-1] : z_q[WL-1];

    cordic_stage #(.WL(WL), .SW(CW)) u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .alpha_i (alpha_rom[cnt_q]),
        .shift_i (cnt_q),
        .d_i     (dir),
        .x_o     (x_nx),
        .y_o     (y_nx),
        .z_o     (z_nx)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [WL-1:0] K_GAIN = WL'(k_gain(FRAC_BITS));
    logic signed [2*WL-1:0] xk, yk;
    logic signed [WL-1:0]   x_comp, y_comp;

    assign xk = (2*WL)'(x_q) * (2*WL)'(K_GAIN);
    assign yk = (2*WL)'(y_q) * (2*WL)'(K_GAIN);
    // Arithmetic shift of the full product floors toward -inf.
    assign x_comp = WL'(xk >>> FRAC_BITS);
    assign y_comp = WL'(yk >>> FRAC_BITS);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    z_d     = z_i;
                    mode_d  = mode_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = x_nx;
                y_d   = y_nx;
                z_d   = z_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = COMP;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
                x_d     = x_comp;
                y_d     = y_comp;
                state_d = DONE;
            end
`endif
            DONE: begin
                // A pending input is not looked at here; it waits for the next IDLE cycle.
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_ROT;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready_o  = rst_n && (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign z_o         = z_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter: driver pushes real-arithmetic expectations, monitor pops on out_valid.
module tb_cordic_iter;

    localparam int WL = 21;
    localparam int FB = 16;
    localparam int IT = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = IT + 1;
    localparam bit GC  = 1'b1;
`else
    localparam int LAT = IT;
    localparam bit GC  = 1'b0;
`endif
    localparam real SC = 65536.0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic signed [WL-1:0] x_i, y_i, z_i, x_o, y_o, z_o;

    cordic_iter #(.WORD_LENGTH(WL), .FRAC_BITS(FB), .ITERATIONS(IT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .x_i         (x_i),
        .y_i         (y_i),
        .z_i         (z_i),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .x_o         (x_o),
        .y_o         (y_o),
        .z_o         (z_o),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        real    x;
        real    y;
        real    z;
        real    tol;
        longint t_acc;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    int     hold_req = 0;
    real    gain;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real cordic_gain();
        real g;
        g = 1.0;
        for (int i = 0; i < IT; i++) g = g * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        if (GC) g = g * $floor(0.6072529350 * SC + 0.5) / SC;
        return g;
    endfunction

    function automatic int srnd(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    task automatic chk(input string nm, input real act, input real exp, input real tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0.2f, want %0.2f +/- %0.1f", nm, act, exp, tol);
        end
    endtask

    task automatic chk_res(input exp_t e);
        chk("x_o", real'(int'(x_o)), e.x, e.tol);
        chk("y_o", real'(int'(y_o)), e.y, e.tol);
        chk("z_o", real'(int'(z_o)), e.z, e.tol);
    endtask

    // Rotation: rotate (x,y) by z and scale by the gain; vectoring: polar magnitude and accumulated angle.
    task automatic issue(input bit m, input int x, input int y, input int z, input real tol);
        exp_t e;
        real  xr, yr, zr;
        @(negedge clk);
        mode = m; x_i = WL'(x); y_i = WL'(y); z_i = WL'(z); in_valid = 1'b1;
        for (int k = 0; k < 400 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready 0 for 400 cycles, want 1");
            in_valid = 1'b0;
            return;
        end
        xr = real'(x); yr = real'(y); zr = real'(z) / SC;
        if (!m) begin
            e.x = gain * (xr * $cos(zr) - yr * $sin(zr));
            e.y = gain * (xr * $sin(zr) + yr * $cos(zr));
            e.z = 0.0;
        end else begin
            e.x = gain * $sqrt(xr * xr + yr * yr);
            e.y = 0.0;
            e.z = real'(z) + $atan2(yr, xr) * SC;
        end
        e.tol   = tol;
        e.t_acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sb.size() != 0 || busy) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending / busy %0d, want 0 / 0", sb.size(), busy);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   hold;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got out_valid with nothing outstanding, want none");
                end else begin
                    e = sb.pop_front();
                    chk("latency", real'(cyc - e.t_acc), real'(LAT), 0.0);
                    chk_res(e);
                    hold = hold_req;
                    for (int h = 0; h < hold; h++) begin
                        @(negedge clk);
                        chk("hold_valid", real'(out_valid), 1.0, 0.0);
                        chk("hold_in_ready", real'(in_ready), 0.0, 0.0);
                        chk_res(e);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                chk("release_in_ready", real'(in_ready), 1.0, 0.0);
            end
        end
    end

    initial begin : driver
        in_valid = 1'b0; mode = 1'b0;
        x_i = '0; y_i = '0; z_i = '0;
        gain = cordic_gain();

        #12;
        chk("rst_out_valid", real'(out_valid), 0.0, 0.0);
        chk("rst_busy", real'(busy), 0.0, 0.0);
        chk("rst_in_ready", real'(in_ready), 0.0, 0.0);
        chk("rst_x", real'(int'(x_o)), 0.0, 0.0);
        chk("rst_z", real'(int'(z_o)), 0.0, 0.0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", real'(in_ready), 1.0, 0.0);

        issue(1'b0, 39797, 0, 51472, 8.0);
        issue(1'b1, 65536, 65536, 0, 8.0);
        issue(1'b0, 39797, 0, -51472, 8.0);
        issue(1'b0, 39797, 0, 0, 8.0);

        // Stall one result for 20 cycles while the next operand waits on in_valid.
        wait_idle();
        hold_req = 20;
        issue(1'b0, 30000, -20000, 30000, 8.0);
        issue(1'b1, 40000, 12345, 1000, 8.0);
        hold_req = 0;

        // Abort an operation at iteration 7, then rerun it from scratch.
        wait_idle();
        issue(1'b0, 39797, 0, 51472, 8.0);
        repeat (7) @(negedge clk);
        chk("busy_mid_run", real'(busy), 1.0, 0.0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", real'(out_valid), 0.0, 0.0);
        chk("abort_busy", real'(busy), 0.0, 0.0);
        chk("abort_x", real'(int'(x_o)), 0.0, 0.0);
        chk("abort_y", real'(int'(y_o)), 0.0, 0.0);
        chk("abort_z", real'(int'(z_o)), 0.0, 0.0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_in_ready", real'(in_ready), 1.0, 0.0);
        issue(1'b0, 39797, 0, 51472, 8.0);

        for (int n = 0; n < 24; n++) begin
            hold_req = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            if ($urandom_range(0, 1) == 0)
                issue(1'b0, srnd(40000), srnd(40000), srnd(98304), 16.0);
            else
                issue(1'b1, int'($urandom_range(16384, 49152)), srnd(49152), srnd(65536), 16.0);
        end

        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end of test by 2 ms, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
